// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM Avalon bridge.
// SDRAM_BRIDGE_TIMEOUT_EN enables the transaction timeout in the bridge top.
package sdram_pkg;

    localparam int unsigned SDRAM_ADDR_W = 32'd23;
    localparam int unsigned SDRAM_DATA_W = 32'd16;

    localparam logic [15:0] SDRAM_INIT_CYCLES    = 16'd10000;
    localparam logic [15:0] SDRAM_TIMEOUT_CYCLES = 16'd4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } sdram_state_t;

endpackage

// File: rtl/sdram_avalon_bridge_if.sv
// Avalon-MM bus between the bridge (master) and the vendor SDRAM controller (slave).
interface sdram_avalon_bridge_if;
    import sdram_pkg::*;

    logic [SDRAM_ADDR_W-1:0] avm_address;
    logic                    avm_read;
    logic                    avm_write;
    logic [SDRAM_DATA_W-1:0] avm_writedata;
    logic [1:0]              avm_byteenable;
    logic [SDRAM_DATA_W-1:0] avm_readdata;
    logic                    avm_readdatavalid;
    logic                    avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );

endinterface

// File: rtl/sdram_init_timer.sv
// Post-lock settle timer: ready rises once pll_locked has been stable for INIT_CYCLES clocks.
module sdram_init_timer
    import sdram_pkg::*;
#(
    parameter logic [15:0] INIT_CYCLES = SDRAM_INIT_CYCLES
) (
    input  logic clk,
    input  logic rst_l,
    input  logic pll_locked,
    output logic ready
);

    logic [15:0] count_r;

    // Saturating settle counter; any loss of lock restarts the interval.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_r <= 16'd0;
            ready   <= 1'b0;
        end else if (!pll_locked) begin
            count_r <= 16'd0;
            ready   <= 1'b0;
        end else begin
            if (count_r != INIT_CYCLES) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
            ready <= (count_r == INIT_CYCLES);
        end
    end

endmodule

// File: rtl/sdram_avalon_bridge.sv
// Converts single-word as/rw requests into Avalon-MM transactions, one outstanding at a time.
// Optional transaction timeout and error flag: define SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_avalon_bridge
    import sdram_pkg::*;
#(
    parameter logic [15:0] INIT_CYCLES    = SDRAM_INIT_CYCLES,
    parameter logic [15:0] TIMEOUT_CYCLES = SDRAM_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    pll_locked,
    output logic                    ready,
    input  logic                    as,
    input  logic                    rw,
    input  logic [SDRAM_ADDR_W-1:0] addr,
    input  logic [SDRAM_DATA_W-1:0] data_write,
    output logic [SDRAM_DATA_W-1:0] data_read,
    output logic                    done,
    output logic                    err,
    sdram_avalon_bridge_if.master   avm
);

    sdram_state_t            state_r;
    logic                    rw_r;
    logic [SDRAM_ADDR_W-1:0] address_r;
    logic [SDRAM_DATA_W-1:0] writedata_r;
    logic [SDRAM_DATA_W-1:0] data_read_r;
    logic                    read_r;
    logic                    write_r;
    logic                    done_r;
    logic                    timeout_s;

    sdram_init_timer #(
        .INIT_CYCLES (INIT_CYCLES)
    ) u_init_timer (
        .clk        (clk),
        .rst_l      (rst_l),
        .pll_locked (pll_locked),
        .ready      (ready)
    );

    // The latched request doubles as the Avalon address/data registers.
    assign avm.avm_address    = address_r;
    assign avm.avm_writedata  = writedata_r;
    assign avm.avm_read       = read_r;
    assign avm.avm_write      = write_r;
    assign avm.avm_byteenable = 2'b11;
    assign data_read          = data_read_r;
    assign done               = done_r;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_count_r;
    logic        err_r;
    logic        tmo_fire_s;
    logic        stray_s;

    assign timeout_s  = (tmo_count_r == (TIMEOUT_CYCLES - 16'd1));
    assign tmo_fire_s = timeout_s &&
                        (((state_r == ISSUE) && avm.avm_waitrequest) ||
                         ((state_r == RD_WAIT) && !avm.avm_readdatavalid));
    // Read data is only legitimate in RD_WAIT or on a zero-latency read acceptance.
    assign stray_s    = avm.avm_readdatavalid &&
                        !((state_r == RD_WAIT) ||
                          ((state_r == ISSUE) && !rw_r && !avm.avm_waitrequest));
    assign err        = err_r;

    // Per-transaction cycle counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tmo_count_r <= 16'd0;
            err_r       <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                tmo_count_r <= 16'd0;
            end else if ((state_r == ISSUE) || (state_r == RD_WAIT)) begin
                tmo_count_r <= tmo_count_r + 16'd1;
            end else begin
                tmo_count_r <= tmo_count_r;
            end
            if (tmo_fire_s || stray_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Transaction FSM with registered Avalon commands and completion outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r     <= IDLE;
            rw_r        <= 1'b0;
            address_r   <= '0;
            writedata_r <= '0;
            data_read_r <= '0;
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (as && ready) begin
                        rw_r        <= rw;
                        address_r   <= addr;
                        writedata_r <= data_write;
                        read_r      <= !rw;
                        write_r     <= rw;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (!avm.avm_waitrequest) begin
                        read_r  <= 1'b0;
                        write_r <= 1'b0;
                        if (rw_r) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else if (avm.avm_readdatavalid) begin
                            data_read_r <= avm.avm_readdata;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= RD_WAIT;
                        end
                    end else if (timeout_s) begin
                        read_r      <= 1'b0;
                        write_r     <= 1'b0;
                        data_read_r <= 16'h0000;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                RD_WAIT: begin
                    if (avm.avm_readdatavalid) begin
                        data_read_r <= avm.avm_readdata;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else if (timeout_s) begin
                        data_read_r <= 16'h0000;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r <= RD_WAIT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
